mult_dot_acc: RTL

- Sequential dot-product stage placed directly downstream of the combinational N x M array multiplier in the synthesis library.
- Accepts a stream of unsigned operand pairs over a valid/ready handshake and multiplies each pair combinationally.
- Registers each product, then accumulates products until a term flagged last arrives.
- Presents the vector sum, term count and overflow flag on a second valid/ready handshake; used for garbled MAC/dot-product circuits.

---
 rtl/mult_dot_acc.sv | 116 +++++++++++
 1 files changed

// File: rtl/mult_dot_acc.sv
// Dot-product accumulator fed by an unsigned N x M multiplier: one product register
// stage, then an accumulator that presents sum/count/overflow once per vector.
module mult_dot_acc #(
  parameter int N  = 8,
  parameter int M  = N,
  parameter int G  = 4,
  parameter int CW = 8,
  localparam int W = N + M + G
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [M-1:0]  in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic [CW-1:0] out_count,
  output logic          out_ovf,
  output logic [0:0]    o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready. Producers
  // hold valid and data stable until the transfer; in_ready depends on registers only,
  // and out_* stay stable while out_valid is high.

  localparam logic [0:0]    ST_ACC  = 1'b0;
  localparam logic [0:0]    ST_DONE = 1'b1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [0:0]    r_state;
  logic          r_first;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic [N+M-1:0] r_p_reg;
  logic          r_p_last;
  logic          r_p_vld;

  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_drain;
  logic [N-1:0]   w_a;
  logic [M-1:0]   w_b;
  logic [N+M-1:0] w_prod;
  logic [W-1:0]   w_acc_base;
  logic [W:0]     w_add;
  logic           w_ovf_base;
  logic [CW-1:0]  w_cnt_next;

  assign w_drain    = r_p_vld && (r_state == ST_ACC);
  assign in_ready   = !r_p_vld || (r_state == ST_ACC);
  assign w_in_fire  = in_valid && in_ready;
  assign out_valid  = (r_state == ST_DONE);
  assign w_out_fire = out_valid && out_ready;

  // Operands are gated so an idle, undriven input bus cannot reach the product register.
  assign w_a    = in_valid ? in_a : '0;
  assign w_b    = in_valid ? in_b : '0;
  assign w_prod = {{M{1'b0}}, w_a} * {{N{1'b0}}, w_b};

  assign w_acc_base = r_first ? '0 : r_acc;
  assign w_ovf_base = r_first ? 1'b0 : r_ovf;
  assign w_add      = {1'b0, w_acc_base} + {{(G+1){1'b0}}, r_p_reg};
  assign w_cnt_next = r_first ? CW'(1) :
                      ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1);

  // Product stage: a new pair may load in the same cycle the old one drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_reg  <= '0;
      r_p_last <= 1'b0;
      r_p_vld  <= 1'b0;
    end else if (w_in_fire) begin
      r_p_reg  <= w_prod;
      r_p_last <= in_last;
      r_p_vld  <= 1'b1;
    end else if (w_drain) begin
      r_p_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_first <= 1'b1;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_drain) begin
            r_acc   <= w_add[W-1:0];
            r_ovf   <= w_ovf_base | w_add[W];
            r_cnt   <= w_cnt_next;
            r_first <= r_p_last;
            if (r_p_last) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (w_out_fire) r_state <= ST_ACC;
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

  assign out_sum     = r_acc;
  assign out_count   = r_cnt;
  assign out_ovf     = r_ovf;
  assign o_dbg_state = r_state;

endmodule
